morse_temporizador_simbolos: RTL and testbench



---
 rtl/morse_temporizador_simbolos.sv | 163 ++++++++++++++++
 tb/tb_morse_temporizador_simbolos.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_temporizador_simbolos.sv
// -----------------------------------------------------------------------------
// morse_temporizador_simbolos
//
// Times one Morse element per valid/ready handshake. Dots and dashes key the
// tone for 1 or 3 units followed by a 1-unit pause. Letter and word gaps are
// silent for 2 or 6 units. A one-cycle o_hecho marks the end of every symbol.
// Illegal codes are consumed and flagged with a one-cycle o_error_cod.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_sym_valid    upstream presents a symbol on i_sym_code
//   i_sym_code     0=dot, 1=dash, 2=letter gap, 3=word gap, 4..7 illegal
//   i_unidad_cfg   unit length in cycles (only with MORSE_VELOCIDAD_CFG_EN)
//   o_sym_ready    block is idle and will accept a symbol
//   o_tono         registered tone/key enable
//   o_ocupado      a symbol is being timed
//   o_hecho        one-cycle pulse at symbol completion
//   o_error_cod    one-cycle pulse when an illegal code is accepted
//
// Build option:
//   MORSE_VELOCIDAD_CFG_EN  adds i_unidad_cfg; its value is latched at each
//                           acceptance (0 treated as 1) and replaces
//                           UNIT_CYCLES for that symbol.
//
// States:
//   S_IDLE  | waiting for a symbol, o_sym_ready high
//   S_TONO  | tone phase of a dot or dash
//   S_PAUSA | silent phase: trailing unit of dot/dash, or a gap symbol
// -----------------------------------------------------------------------------
module morse_temporizador_simbolos #(
    parameter logic [27:0] UNIT_CYCLES = 28'd12_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_sym_valid,
    input  logic [2:0]  i_sym_code,
`ifdef MORSE_VELOCIDAD_CFG_EN
    input  logic [27:0] i_unidad_cfg,
`endif
    output logic        o_sym_ready,
    output logic        o_tono,
    output logic        o_ocupado,
    output logic        o_hecho,
    output logic        o_error_cod
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TONO  = 2'd1;
    localparam logic [1:0] S_PAUSA = 2'd2;

    logic [1:0]  r_state;
    logic [27:0] r_cyc;
    logic [2:0]  r_unit;
    logic [2:0]  r_len;      // length in units of the current phase
    logic        r_tono;
    logic        r_ocupado;
    logic        r_hecho;
    logic        r_error;

    logic        w_accept;
    logic        w_legal;
    logic        w_is_tone;
    logic [27:0] w_unit_last;
    logic        w_unit_tick;
    logic        w_phase_end;

    assign o_sym_ready = (r_state == S_IDLE);
    assign w_accept    = i_sym_valid & o_sym_ready;
    assign w_legal     = ~i_sym_code[2];
    assign w_is_tone   = ~i_sym_code[1];

`ifdef MORSE_VELOCIDAD_CFG_EN
    logic [27:0] r_unidad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_unidad <= 28'd1;
        end else if (w_accept) begin
            r_unidad <= (i_unidad_cfg == 28'd0) ? 28'd1 : i_unidad_cfg;
        end
    end

    assign w_unit_last = r_unidad - 28'd1;
`else
    assign w_unit_last = UNIT_CYCLES - 28'd1;
`endif

    // The cycle counter is held at 0 in IDLE, so it never passes the compare
    // value and cannot wrap.
    assign w_unit_tick = (r_state != S_IDLE) && (r_cyc == w_unit_last);
    assign w_phase_end = w_unit_tick && (r_unit == (r_len - 3'd1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cyc     <= 28'd0;
            r_unit    <= 3'd0;
            r_len     <= 3'd1;
            r_tono    <= 1'b0;
            r_ocupado <= 1'b0;
            r_hecho   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_hecho <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cyc  <= 28'd0;
                    r_unit <= 3'd0;
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_error <= 1'b1;
                        end else if (w_is_tone) begin
                            r_state   <= S_TONO;
                            r_tono    <= 1'b1;
                            r_ocupado <= 1'b1;
                            r_len     <= i_sym_code[0] ? 3'd3 : 3'd1;
                        end else begin
                            r_state   <= S_PAUSA;
                            r_ocupado <= 1'b1;
                            r_len     <= i_sym_code[0] ? 3'd6 : 3'd2;
                        end
                    end
                end
                S_TONO, S_PAUSA: begin
                    if (w_phase_end) begin
                        r_cyc  <= 28'd0;
                        r_unit <= 3'd0;
                        if (r_state == S_TONO) begin
                            // Dot and dash always end with a single silent unit.
                            r_state <= S_PAUSA;
                            r_tono  <= 1'b0;
                            r_len   <= 3'd1;
                        end else begin
                            r_state   <= S_IDLE;
                            r_ocupado <= 1'b0;
                            r_hecho   <= 1'b1;
                        end
                    end else if (w_unit_tick) begin
                        r_cyc  <= 28'd0;
                        r_unit <= r_unit + 3'd1;
                    end else begin
                        r_cyc <= r_cyc + 28'd1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cyc     <= 28'd0;
                    r_unit    <= 3'd0;
                    r_tono    <= 1'b0;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign o_tono      = r_tono;
    assign o_ocupado   = r_ocupado;
    assign o_hecho     = r_hecho;
    assign o_error_cod = r_error;

endmodule

// File: tb/tb_morse_temporizador_simbolos.sv
// Bench for morse_temporizador_simbolos. Instance A (4-cycle unit) is driven
// with directed and random symbols; expected events are queued at acceptance
// and a monitor checks them. Instance B (1-cycle unit) runs a continuous
// stream whose expected per-cycle tone/done trace is queued at acceptance.
module tb_morse_temporizador_simbolos;

    localparam logic [27:0] U_A = 28'd4;
    localparam logic [27:0] U_B = 28'd1;
    localparam int TMO = 400;
    localparam int NB  = 11;

    typedef struct {
        bit is_err;
        int ev_cyc;
        int ton_first;
        int ton_cnt;
    } exp_t;

    typedef struct {
        bit t;
        bit h;
    } tr_t;

    exp_t sb_q[$];
    tr_t  tr_q[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n_b = 1'b0;
    logic       sym_valid = 1'b0;
    logic [2:0] sym_code = 3'd0;
    logic       sym_ready, tono, ocupado, hecho, error_cod;
    logic       b_valid = 1'b0;
    logic [2:0] b_code = 3'd0;
    logic       b_ready, b_tono, b_ocup, b_hecho, b_err;
`ifdef MORSE_VELOCIDAD_CFG_EN
    logic [27:0] unidad_cfg = 28'd4;
    logic [27:0] unidad_cfg_b = 28'd0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_off = 1'b1;
    bit b_fin = 1'b0;
    bit b_ok = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    morse_temporizador_simbolos #(.UNIT_CYCLES(U_A)) dut_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sym_valid (sym_valid),
        .i_sym_code  (sym_code),
`ifdef MORSE_VELOCIDAD_CFG_EN
        .i_unidad_cfg(unidad_cfg),
`endif
        .o_sym_ready (sym_ready),
        .o_tono      (tono),
        .o_ocupado   (ocupado),
        .o_hecho     (hecho),
        .o_error_cod (error_cod)
    );

    morse_temporizador_simbolos #(.UNIT_CYCLES(U_B)) dut_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n_b),
        .i_sym_valid (b_valid),
        .i_sym_code  (b_code),
`ifdef MORSE_VELOCIDAD_CFG_EN
        .i_unidad_cfg(unidad_cfg_b),
`endif
        .o_sym_ready (b_ready),
        .o_tono      (b_tono),
        .o_ocupado   (b_ocup),
        .o_hecho     (b_hecho),
        .o_error_cod (b_err)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Element lengths in units, straight from the Morse timing table.
    function automatic int on_units(input logic [2:0] c);
        case (c)
            3'd0:    return 1;
            3'd1:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic int off_units(input logic [2:0] c);
        case (c)
            3'd0, 3'd1: return 1;
            3'd2:       return 2;
            3'd3:       return 6;
            default:    return 0;
        endcase
    endfunction

    function automatic int unit_now();
`ifdef MORSE_VELOCIDAD_CFG_EN
        return (unidad_cfg == 28'd0) ? 1 : int'(unidad_cfg);
`else
        return int'(U_A);
`endif
    endfunction

    // Called at a falling edge; returns at the falling edge where the DUT is
    // ready again, leaving sym_valid as the busy-time garbage left it.
    task automatic send(input logic [2:0] code);
        int   n;
        int   a;
        int   u;
        bit   legal;
        exp_t e;
        sym_valid = 1'b1;
        sym_code  = code;
        n = 0;
        while (!sym_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (!sym_ready) begin
            chk("accept_timeout", sym_ready, 1);
            return;
        end
        a = cyc;
        u = unit_now();
        legal = (code < 3'd4);
        e.is_err    = !legal;
        e.ev_cyc    = legal ? a + (on_units(code) + off_units(code)) * u + 1 : a + 1;
        e.ton_first = a + 1;
        e.ton_cnt   = on_units(code) * u;
        sb_q.push_back(e);
        @(negedge clk);
        chk("ocupado_after_accept", ocupado, int'(legal));
        chk("tono_after_accept", tono, int'(on_units(code) > 0));
        if (legal) begin
            sym_code  = 3'($urandom_range(0, 7));
            sym_valid = 1'($urandom_range(0, 1));
`ifdef MORSE_VELOCIDAD_CFG_EN
            unidad_cfg = 28'($urandom_range(0, 5));
`endif
        end else begin
            sym_valid = 1'b0;
        end
        n = 0;
        while (!sym_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        chk("ready_cycle", cyc, e.ev_cyc);
    endtask

    task automatic reset_mid_dash();
        int a;
        chk("ready_before_dash", sym_ready, 1);
        sym_valid = 1'b1;
        sym_code  = 3'd1;
        a = cyc;
        @(negedge clk);
        sym_valid = 1'b0;
        while (cyc < a + 5) @(negedge clk);
        chk("tono_mid_dash", tono, 1);
        mon_off = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("tono_async_drop", tono, 0);
        chk("ocupado_async_drop", ocupado, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("ready_after_release", sym_ready, 1);
            chk("no_hecho_after_reset", hecho, 0);
            chk("tono_after_release", tono, 0);
        end
        mon_off = 1'b0;
    endtask

    initial begin : monitor
        int   tcnt;
        int   tfirst;
        int   tlast;
        exp_t e;
        tcnt = 0;
        tfirst = -1;
        tlast = -1;
        forever begin
            @(negedge clk);
            if (mon_off) begin
                tcnt = 0;
                tfirst = -1;
                tlast = -1;
            end else begin
                if (tono) begin
                    if (tcnt == 0) tfirst = cyc;
                    tlast = cyc;
                    tcnt++;
                end
                if (hecho || error_cod) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_event", int'(hecho) + int'(error_cod), 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("event_hecho", hecho, int'(!e.is_err));
                        chk("event_error", error_cod, int'(e.is_err));
                        chk("event_cycle", cyc, e.ev_cyc);
                        chk("tono_cycles", tcnt, e.ton_cnt);
                        if (e.ton_cnt > 0) begin
                            chk("tono_first", tfirst, e.ton_first);
                            chk("tono_last", tlast, e.ton_first + e.ton_cnt - 1);
                        end
                    end
                    tcnt = 0;
                    tfirst = -1;
                    tlast = -1;
                end
            end
        end
    end

    initial begin : stream_b
        logic [2:0] list [NB];
        int   idx;
        bit   started;
        tr_t  t;
        list[0] = 3'd0;
        list[1] = 3'd2;
        list[2] = 3'd0;
        for (int i = 3; i < NB; i++) list[i] = 3'($urandom_range(0, 3));
        idx = 0;
        started = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_b = 1'b1;
        for (int c = 0; c < TMO && !(idx == NB && tr_q.size() == 0); c++) begin
            @(negedge clk);
            if (started && tr_q.size() != 0) begin
                t = tr_q.pop_front();
                chk("b_tono", b_tono, int'(t.t));
                chk("b_hecho", b_hecho, int'(t.h));
                chk("b_ready", b_ready, int'(t.h));
            end
            if (b_ready && idx < NB) begin
                b_valid = 1'b1;
                b_code  = list[idx];
                for (int k = 0; k < on_units(list[idx]); k++) tr_q.push_back('{t: 1'b1, h: 1'b0});
                for (int k = 0; k < off_units(list[idx]); k++) tr_q.push_back('{t: 1'b0, h: 1'b0});
                tr_q.push_back('{t: 1'b0, h: 1'b1});
                idx++;
                started = 1'b1;
            end else if (b_ready) begin
                b_valid = 1'b0;
            end
        end
        b_ok  = (idx == NB) && (tr_q.size() == 0);
        b_fin = 1'b1;
    end

    initial begin : main
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tono", tono, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_hecho", hecho, 0);
        chk("rst_error", error_cod, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", sym_ready, 1);
        mon_off = 1'b0;

        send(3'd0);
        send(3'd1);
        send(3'd3);
        send(3'd5);
        sym_valid = 1'b0;
        @(negedge clk);
        reset_mid_dash();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                sym_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send(3'($urandom_range(0, 7)));
        end
        sym_valid = 1'b0;

        n = 0;
        while ((sb_q.size() != 0 || !b_fin) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("stream_b_complete", int'(b_ok), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
